// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    STARTUP,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int DEF_CLKS_PER_BIT = 5000;
  localparam int DATA_BITS        = 8;

endpackage

// File: rtl/uart_txer_if.sv
// Host-side byte handshake: the host offers data_in under data_valid, the transmitter answers data_ready.
interface uart_txer_if;

  logic [uart_pkg::DATA_BITS-1:0] data_in;
  logic                           data_valid;
  logic                           data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO; dout always shows the oldest entry.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             din,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // NOTE: the storage array is deliberately not reset; count gates every read, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/uart_txer.sv
// 8N1 UART transmitter: byte FIFO feeding a start/data/stop serialiser, with a guaranteed idle mark after reset.
module uart_txer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT      = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH        = 4,
  parameter int STARTUP_IDLE_BITS = 16
) (
  input  logic          clk,
  input  logic          res,
  uart_txer_if.slave    host,
  output logic          TX,
  output logic          tx_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int SW = $clog2(STARTUP_IDLE_BITS);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] SU_LAST    = SW'(STARTUP_IDLE_BITS - 1);
  localparam logic [2:0]    BIT_LAST   = 3'(DATA_BITS - 1);

  state_t                 state, state_d;
  logic [TW-1:0]          timer, timer_d;
  logic [2:0]             bit_idx, bit_idx_d;
  logic [SW-1:0]          su_cnt, su_cnt_d;
  logic [DATA_BITS-1:0]   shift, shift_d;
  logic                   tx_d;
  logic                   period_end;

  logic                   push;
  logic                   pop;
  logic [DATA_BITS-1:0]   fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .wr_en (push),
    .din   (host.data_in),
    .rd_en (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign period_end = (timer == TIMER_LAST);

  // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (res) begin
      state   <= STARTUP;
      timer   <= '0;
      bit_idx <= '0;
      su_cnt  <= '0;
      shift   <= '0;
      TX      <= 1'b1;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      bit_idx <= bit_idx_d;
      su_cnt  <= su_cnt_d;
      shift   <= shift_d;
      TX      <= tx_d;
    end
  end

  // NOTE: every variable gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    timer_d   = period_end ? '0 : timer + 1'b1;
    bit_idx_d = bit_idx;
    su_cnt_d  = su_cnt;
    shift_d   = shift;
    tx_d      = TX;
    case (state)
      STARTUP: begin
        tx_d = 1'b1;
        if (period_end) begin
          su_cnt_d = su_cnt + 1'b1;
          if (su_cnt == SU_LAST) state_d = IDLE;
        end
      end
      IDLE: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (pop) begin
          shift_d = fifo_dout;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (period_end) begin
          tx_d      = shift[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (period_end) begin
          if (bit_idx == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // shift[1] is the bit that becomes shift[0] after this edge
            bit_idx_d = bit_idx + 1'b1;
            shift_d   = shift >> 1;
            tx_d      = shift[1];
          end
        end
      end
      STOP: begin
        if (period_end) begin
          if (pop) begin
            shift_d = fifo_dout;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready uses the pre-pop count, so a push into a full FIFO is refused even when a pop coincides.
  always_comb begin
    host.data_ready = !fifo_full;
    push            = host.data_valid && !fifo_full;
    pop             = !fifo_empty && ((state == IDLE) || ((state == STOP) && period_end));
    tx_busy         = (state != IDLE) || (fifo_count != '0);
  end

endmodule
